// File: rtl/dino_pkg.sv
// -----------------------------------------------------------------------------
// dino_pkg
// Shared definitions for the dino obstacle game controller.
//   - Row / obstacle codes (2-bit): NO_OBS, DINO_TOP, DINO_MID, DINO_BOT
//   - Game state encoding: ST_IDLE, ST_PLAY, ST_OVER, ST_CLEAR
//   - Helper functions for the score, index and speed-up arithmetic
// Optional feature macro used by the users of this package: DINO_SPEEDUP_EN
// -----------------------------------------------------------------------------
package dino_pkg;

  localparam logic [1:0] NO_OBS   = 2'b00;
  localparam logic [1:0] DINO_TOP = 2'b01;
  localparam logic [1:0] DINO_MID = 2'b10;
  localparam logic [1:0] DINO_BOT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_PLAY  = 2'b01,
    ST_OVER  = 2'b10,
    ST_CLEAR = 2'b11
  } dino_state_e;

  // Saturating 8-bit increment (score and shift count stop at 255).
  function automatic logic [7:0] sat_inc8(input logic [7:0] val);
    logic [7:0] res;
    if (val == 8'hFF) begin
      res = 8'hFF;
    end else begin
      res = val + 8'd1;
    end
    return res;
  endfunction

  // Modulo increment of the obstacle sequence index: last wraps to 0.
  function automatic logic [4:0] wrap_inc5(input logic [4:0] val,
                                           input logic [4:0] last);
    logic [4:0] res;
    if (val >= last) begin
      res = 5'd0;
    end else begin
      res = val + 5'd1;
    end
    return res;
  endfunction

  // Next period after a speed-up event: max(period - step, floor).
  // Written as a comparison on the distance to the floor so that the
  // 24-bit subtraction can never wrap below the floor.
  function automatic logic [23:0] speedup_period(input logic [23:0] period,
                                                 input logic [23:0] step,
                                                 input logic [23:0] floor);
    logic [23:0] res;
    if ((period >= floor) && ((period - floor) >= step)) begin
      res = period - step;
    end else begin
      res = floor;
    end
    return res;
  endfunction

endpackage

// File: rtl/dino_tick_gen.sv
// -----------------------------------------------------------------------------
// dino_tick_gen
// Obstacle step timer. Counts 0..period while run is high and raises tick for
// the cycle in which the count equals the period. With DINO_SPEEDUP_EN defined
// the period shrinks by PERIOD_STEP every SPEEDUP_EVERY ticks, floored at
// MIN_PERIOD; otherwise the period is fixed at BASE_PERIOD.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   run        : count enable (game in PLAY)
//   clr        : restart - counter to 0, period back to BASE_PERIOD
//   hold       : suppress the tick this cycle (collision takes priority)
//   tick       : combinational step request, registered by the parent
// -----------------------------------------------------------------------------
module dino_tick_gen
  import dino_pkg::*;
#(
  parameter logic [23:0] BASE_PERIOD   = 24'd500,
  parameter logic [23:0] MIN_PERIOD    = 24'd100,
  parameter logic [23:0] PERIOD_STEP   = 24'd50,
  parameter logic [7:0]  SPEEDUP_EVERY = 8'd5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clr,
  input  logic hold,
  output logic tick
);

  logic [23:0] cnt_r;
  logic [23:0] period_s;
  logic        wrap_s;

  // The counter wraps even when the tick is held off; the parent leaves PLAY
  // in that case, so the interval restart is irrelevant.
  assign wrap_s = run && (cnt_r == period_s);
  assign tick   = wrap_s && !hold;

  // Period counter: 0..period while running, frozen otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= 24'd0;
    end else if (clr) begin
      cnt_r <= 24'd0;
    end else if (wrap_s) begin
      cnt_r <= 24'd0;
    end else if (run) begin
      cnt_r <= cnt_r + 24'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

`ifdef DINO_SPEEDUP_EN
  logic [23:0] period_r;
  logic [7:0]  speed_cnt_r;

  assign period_s = period_r;

  // Speed-up: shorten the period after every SPEEDUP_EVERY-th tick; the new
  // value is picked up by the interval that starts on the next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_r    <= BASE_PERIOD;
      speed_cnt_r <= 8'd0;
    end else if (clr) begin
      period_r    <= BASE_PERIOD;
      speed_cnt_r <= 8'd0;
    end else if (tick) begin
      if (speed_cnt_r >= (SPEEDUP_EVERY - 8'd1)) begin
        speed_cnt_r <= 8'd0;
        period_r    <= speedup_period(period_r, PERIOD_STEP, MIN_PERIOD);
      end else begin
        speed_cnt_r <= speed_cnt_r + 8'd1;
        period_r    <= period_r;
      end
    end else begin
      period_r    <= period_r;
      speed_cnt_r <= speed_cnt_r;
    end
  end
`else
  logic unused_cfg_s;

  assign period_s     = BASE_PERIOD;
  // Speed-up parameters have no function in the fixed-period build.
  assign unused_cfg_s = ^{MIN_PERIOD, PERIOD_STEP, SPEEDUP_EVERY};
`endif

endmodule

// File: rtl/dino_game_ctrl.sv
// -----------------------------------------------------------------------------
// dino_game_ctrl
// Game-flow controller for the dino obstacle game. Owns the IDLE/PLAY/OVER/
// CLEAR state machine, the obstacle sequence index, the score and the shift
// count, and drives the obstacle shift and flush strobes. All outputs are
// registered. Optional speed-up feature: define DINO_SPEEDUP_EN.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   start_pulse : one-cycle (re)start strobe, ignored while in PLAY
//   dino_pos    : dino row (01 top, 10 mid, 11 bottom)
//   obs_head    : obstacle in the dino column, 00 = none
//   shift_en    : one-cycle obstacle shift / sequence load strobe
//   obs_index   : sequence index to load on the next shift_en
//   flush       : one-cycle datapath clear at the start of a game
//   state       : 00 IDLE, 01 PLAY, 10 OVER, 11 CLEAR
//   game_over   : high while in OVER
//   game_clear  : high while in CLEAR
//   score       : shifts in the current game, saturating at 255
// -----------------------------------------------------------------------------
module dino_game_ctrl
  import dino_pkg::*;
#(
  parameter logic [23:0] BASE_PERIOD   = 24'd500,
  parameter logic [23:0] MIN_PERIOD    = 24'd100,
  parameter logic [23:0] PERIOD_STEP   = 24'd50,
  parameter logic [7:0]  SPEEDUP_EVERY = 8'd5,
  parameter logic [4:0]  SEQ_LEN       = 5'd20,
  parameter logic [7:0]  CLEAR_SHIFTS  = 8'd28
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_pulse,
  input  logic [1:0] dino_pos,
  input  logic [1:0] obs_head,
  output logic       shift_en,
  output logic [4:0] obs_index,
  output logic       flush,
  output logic [1:0] state,
  output logic       game_over,
  output logic       game_clear,
  output logic [7:0] score
);

  dino_state_e state_r;
  dino_state_e state_nxt_s;

  logic        play_s;
  logic        collision_s;
  logic        start_s;
  logic        tick_s;
  logic        last_shift_s;

  logic        shift_en_r;
  logic        flush_r;
  logic        game_over_r;
  logic        game_clear_r;
  logic [4:0]  obs_index_r;
  logic [7:0]  score_r;
  logic [7:0]  shift_cnt_r;

  logic        shift_en_nxt_s;
  logic        flush_nxt_s;
  logic        game_over_nxt_s;
  logic        game_clear_nxt_s;

  assign play_s       = (state_r == ST_PLAY);
  assign collision_s  = play_s && (obs_head != NO_OBS) && (obs_head == dino_pos);
  // A start is only honoured outside PLAY.
  assign start_s      = !play_s && start_pulse;
  assign last_shift_s = (shift_cnt_r == (CLEAR_SHIFTS - 8'd1));

  dino_tick_gen #(
    .BASE_PERIOD   (BASE_PERIOD),
    .MIN_PERIOD    (MIN_PERIOD),
    .PERIOD_STEP   (PERIOD_STEP),
    .SPEEDUP_EVERY (SPEEDUP_EVERY)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (play_s),
    .clr   (start_s),
    .hold  (collision_s),
    .tick  (tick_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; collision outranks the clearing tick.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE, ST_OVER, ST_CLEAR: begin
        if (start_pulse) begin
          state_nxt_s = ST_PLAY;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_PLAY: begin
        if (collision_s) begin
          state_nxt_s = ST_OVER;
        end else if (tick_s && last_shift_s) begin
          state_nxt_s = ST_CLEAR;
        end else begin
          state_nxt_s = ST_PLAY;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Output decode, computed one cycle ahead so the strobes and status flags
  // line up with the registered state.
  always_comb begin
    shift_en_nxt_s   = tick_s;
    flush_nxt_s      = start_s;
    game_over_nxt_s  = 1'b0;
    game_clear_nxt_s = 1'b0;
    case (state_nxt_s)
      ST_OVER: begin
        game_over_nxt_s = 1'b1;
      end
      ST_CLEAR: begin
        game_clear_nxt_s = 1'b1;
      end
      default: begin
        game_over_nxt_s  = 1'b0;
        game_clear_nxt_s = 1'b0;
      end
    endcase
  end

  // Output registers for strobes and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_en_r   <= 1'b0;
      flush_r      <= 1'b0;
      game_over_r  <= 1'b0;
      game_clear_r <= 1'b0;
    end else begin
      shift_en_r   <= shift_en_nxt_s;
      flush_r      <= flush_nxt_s;
      game_over_r  <= game_over_nxt_s;
      game_clear_r <= game_clear_nxt_s;
    end
  end

  // Game progress: index, score and shift count, cleared on start and
  // advanced on each (unsuppressed) tick, so they change together with
  // the rising edge of shift_en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      obs_index_r <= 5'd0;
      score_r     <= 8'd0;
      shift_cnt_r <= 8'd0;
    end else if (start_s) begin
      obs_index_r <= 5'd0;
      score_r     <= 8'd0;
      shift_cnt_r <= 8'd0;
    end else if (tick_s) begin
      obs_index_r <= wrap_inc5(obs_index_r, SEQ_LEN - 5'd1);
      score_r     <= sat_inc8(score_r);
      shift_cnt_r <= sat_inc8(shift_cnt_r);
    end else begin
      obs_index_r <= obs_index_r;
      score_r     <= score_r;
      shift_cnt_r <= shift_cnt_r;
    end
  end

  assign shift_en   = shift_en_r;
  assign flush      = flush_r;
  assign state      = state_r;
  assign game_over  = game_over_r;
  assign game_clear = game_clear_r;
  assign obs_index  = obs_index_r;
  assign score      = score_r;

endmodule

// File: tb/tb_dino_game_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dino_game_ctrl
// Self-checking bench for dino_game_ctrl with default parameters. Expected
// shift events (index, score, spacing) are queued when a game is started and
// popped as shift_en pulses arrive; collision decoding is table-driven.
// Honours DINO_SPEEDUP_EN for the expected shift spacing.
// -----------------------------------------------------------------------------
module tb_dino_game_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_pulse;
  logic [1:0] dino_pos;
  logic [1:0] obs_head;
  logic       shift_en;
  logic [4:0] obs_index;
  logic       flush;
  logic [1:0] state;
  logic       game_over;
  logic       game_clear;
  logic [7:0] score;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [4:0] idx;
    logic [7:0] score;
    int         gap;
  } shift_exp_t;

  typedef struct {
    logic [1:0] pos;
    logic [1:0] head;
    logic [1:0] exp_state;
    logic       exp_over;
  } coll_vec_t;

  shift_exp_t sb[$];
  coll_vec_t  vecs[7];

  dino_game_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_pulse (start_pulse),
    .dino_pos    (dino_pos),
    .obs_head    (obs_head),
    .shift_en    (shift_en),
    .obs_index   (obs_index),
    .flush       (flush),
    .state       (state),
    .game_over   (game_over),
    .game_clear  (game_clear),
    .score       (score)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Cycles from the previous shift (or the flush cycle) to shift number k.
  function automatic int exp_gap(input int k);
    int p;
`ifdef DINO_SPEEDUP_EN
    p = 500 - 50 * ((k - 1) / 5);
    if (p < 100) p = 100;
`else
    p = 500;
`endif
    return p + 1;
  endfunction

  task automatic push_shifts(input int first_k, input int n);
    shift_exp_t rec;
    for (int j = 0; j < n; j++) begin
      rec.idx   = 5'((first_k + j) % 20);
      rec.score = 8'(first_k + j);
      rec.gap   = exp_gap(first_k + j);
      sb.push_back(rec);
    end
  endtask

  // Must be entered in the flush cycle; pops one record per shift_en pulse.
  task automatic run_shifts(input int budget);
    shift_exp_t rec;
    int cyc = 0;
    int gap = 0;
    int flush_seen = 0;
    while (sb.size() != 0 && cyc < budget) begin
      step();
      cyc++;
      gap++;
      if (flush) flush_seen++;
      if (shift_en) begin
        rec = sb.pop_front();
        chk("shift_gap", gap, rec.gap);
        chk("shift_obs_index", obs_index, rec.idx);
        chk("shift_score", score, rec.score);
        gap = 0;
      end
    end
    chk("scoreboard_drained", sb.size(), 0);
    chk("no_flush_during_play", flush_seen, 0);
    sb.delete();
  endtask

  task automatic start_game(input string tag);
    start_pulse = 1'b1;
    step();
    start_pulse = 1'b0;
    chk({tag, "_flush"}, flush, 1);
    chk({tag, "_state"}, state, 1);
    chk({tag, "_score"}, score, 0);
    chk({tag, "_obs_index"}, obs_index, 0);
    chk({tag, "_game_over"}, game_over, 0);
    chk({tag, "_game_clear"}, game_clear, 0);
  endtask

  initial begin
    int pulses;

    vecs[0] = '{2'b01, 2'b01, 2'b10, 1'b1};
    vecs[1] = '{2'b10, 2'b10, 2'b10, 1'b1};
    vecs[2] = '{2'b11, 2'b11, 2'b10, 1'b1};
    vecs[3] = '{2'b01, 2'b10, 2'b01, 1'b0};
    vecs[4] = '{2'b11, 2'b00, 2'b01, 1'b0};
    vecs[5] = '{2'b00, 2'b00, 2'b01, 1'b0};
    vecs[6] = '{2'b10, 2'b01, 2'b01, 1'b0};

    rst_n       = 1'b0;
    start_pulse = 1'b0;
    dino_pos    = 2'b01;
    obs_head    = 2'b00;
    repeat (3) step();
    chk("rst_state", state, 0);
    chk("rst_shift_en", shift_en, 0);
    chk("rst_flush", flush, 0);
    chk("rst_obs_index", obs_index, 0);
    chk("rst_score", score, 0);
    chk("rst_game_over", game_over, 0);
    chk("rst_game_clear", game_clear, 0);
    rst_n = 1'b1;
    repeat (3) step();
    chk("idle_hold_state", state, 0);

    // Full game to CLEAR: 28 shifts, index wraps 19 -> 0 on shift 20.
    start_game("clear_start");
    step();
    chk("flush_one_cycle", flush, 0);
    push_shifts(2, 27);
    begin
      // First shift handled by hand to cover the 501-cycle latency.
      int n = 1;
      while (!shift_en && n < 600) begin
        step();
        n++;
      end
      chk("first_shift_latency", n, 501);
      chk("first_obs_index", obs_index, 1);
      chk("first_score", score, 1);
    end
    run_shifts(15000);
    chk("clear_state", state, 3);
    chk("clear_game_clear", game_clear, 1);
    chk("clear_score", score, 28);
    chk("clear_obs_index", obs_index, 8);
    pulses = 0;
    repeat (600) begin
      step();
      if (shift_en) pulses++;
    end
    chk("clear_no_more_shifts", pulses, 0);
    chk("clear_hold_state", state, 3);
    chk("clear_hold_score", score, 28);

    // Restart from CLEAR, play 7 shifts, then collide mid-interval.
    start_game("restart_clear");
    push_shifts(1, 7);
    run_shifts(4000);
    repeat (10) step();
    dino_pos = 2'b10;
    obs_head = 2'b10;
    step();
    obs_head = 2'b00;
    dino_pos = 2'b01;
    chk("coll_state", state, 2);
    chk("coll_game_over", game_over, 1);
    chk("coll_score", score, 7);
    chk("coll_obs_index", obs_index, 7);
    pulses = 0;
    repeat (600) begin
      step();
      if (shift_en) pulses++;
    end
    chk("over_no_shifts", pulses, 0);
    chk("over_hold_score", score, 7);
    chk("over_hold_state", state, 2);

    // Restart from OVER, one shift, then a start inside PLAY is ignored.
    start_game("restart_over");
    push_shifts(1, 1);
    run_shifts(600);
    repeat (5) step();
    start_pulse = 1'b1;
    step();
    start_pulse = 1'b0;
    chk("play_start_ignored_flush", flush, 0);
    chk("play_start_ignored_state", state, 1);
    chk("play_start_ignored_score", score, 1);

    // Asynchronous reset mid-game, checked before any clock edge.
    rst_n = 1'b0;
    #1;
    chk("async_rst_state", state, 0);
    chk("async_rst_score", score, 0);
    chk("async_rst_obs_index", obs_index, 0);
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_flush", flush, 0);
    chk("post_rst_state", state, 0);

    // Collision in the very cycle the period counter wraps.
    start_game("tick_coll");
    repeat (500) step();
    dino_pos = 2'b11;
    obs_head = 2'b11;
    step();
    obs_head = 2'b00;
    dino_pos = 2'b01;
    chk("tick_coll_shift_en", shift_en, 0);
    chk("tick_coll_state", state, 2);
    chk("tick_coll_score", score, 0);
    chk("tick_coll_obs_index", obs_index, 0);

    // Collision decode table.
    for (int i = 0; i < 7; i++) begin
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      start_pulse = 1'b1;
      step();
      start_pulse = 1'b0;
      repeat (3) step();
      dino_pos = vecs[i].pos;
      obs_head = vecs[i].head;
      step();
      chk($sformatf("vec%0d_state", i), state, vecs[i].exp_state);
      chk($sformatf("vec%0d_game_over", i), game_over, vecs[i].exp_over);
      obs_head = 2'b00;
      dino_pos = 2'b01;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
